// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with registered one-hot grant, encoded index
// and a programmable hold limit that forces re-arbitration under contention.
module rr_arbiter8 #(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid,
  output logic       gnt_new
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  localparam logic [7:0] MAX_HOLD_C = 8'(MAX_HOLD);

  state_t     state_r, state_n;
  logic [2:0] ptr_r, ptr_n;
  logic [7:0] hold_cnt_r, hold_cnt_n;
  logic [7:0] gnt_r, gnt_n;
  logic [2:0] gnt_idx_r, gnt_idx_n;
  logic       gnt_valid_r, gnt_valid_n;
  logic       gnt_new_r, gnt_new_n;

  logic [3:0] win_s;
  logic       holder_req_s;
  logic       others_s;
  logic       grant_s;
  logic       clear_s;

  // Returns {found, index} of the first set bit scanning upward from start, wrapping 7->0.
  function automatic logic [3:0] scan_winner(input logic [7:0] r, input logic [2:0] start);
    logic [3:0] res;
    logic [2:0] idx;
    res = 4'b0000;
    for (int k = 7; k >= 0; k--) begin
      idx = start + 3'(k);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  function automatic logic [7:0] onehot8(input logic [2:0] idx);
    return 8'b0000_0001 << idx;
  endfunction

  // Next-state and next-output decision for the IDLE/GRANT machine.
  always_comb begin
    win_s        = scan_winner(req, ptr_r);
    holder_req_s = |(req & gnt_r);
    others_s     = |(req & ~gnt_r);
    grant_s      = 1'b0;
    clear_s      = 1'b0;
    state_n      = state_r;
    ptr_n        = ptr_r;
    hold_cnt_n   = hold_cnt_r;
    gnt_n        = gnt_r;
    gnt_idx_n    = gnt_idx_r;
    gnt_valid_n  = gnt_valid_r;
    gnt_new_n    = 1'b0;

    case (state_r)
      IDLE: begin
        if (win_s[3]) grant_s = 1'b1;
        else          clear_s = 1'b1;
      end
      GRANT: begin
        if (!holder_req_s) begin
          if (win_s[3]) grant_s = 1'b1;
          else          clear_s = 1'b1;
        end else if ((MAX_HOLD_C == 8'd0) || (hold_cnt_r < MAX_HOLD_C)) begin
          if (hold_cnt_r != 8'hFF) hold_cnt_n = hold_cnt_r + 8'd1;
          else                     hold_cnt_n = hold_cnt_r;
        end else if (others_s) begin
          // Holder sits last in the scan since ptr already points past it.
          grant_s = 1'b1;
        end else begin
          hold_cnt_n = hold_cnt_r;
        end
      end
      default: clear_s = 1'b1;
    endcase

    if (grant_s) begin
      state_n     = GRANT;
      gnt_n       = onehot8(win_s[2:0]);
      gnt_idx_n   = win_s[2:0];
      gnt_valid_n = 1'b1;
      gnt_new_n   = 1'b1;
      hold_cnt_n  = 8'd1;
      ptr_n       = win_s[2:0] + 3'd1;
    end else if (clear_s) begin
      state_n     = IDLE;
      gnt_n       = 8'h00;
      gnt_idx_n   = 3'd0;
      gnt_valid_n = 1'b0;
      hold_cnt_n  = 8'd0;
    end else begin
      state_n     = state_r;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      ptr_r       <= 3'd0;
      hold_cnt_r  <= 8'd0;
      gnt_r       <= 8'h00;
      gnt_idx_r   <= 3'd0;
      gnt_valid_r <= 1'b0;
      gnt_new_r   <= 1'b0;
    end else begin
      state_r     <= state_n;
      ptr_r       <= ptr_n;
      hold_cnt_r  <= hold_cnt_n;
      gnt_r       <= gnt_n;
      gnt_idx_r   <= gnt_idx_n;
      gnt_valid_r <= gnt_valid_n;
      gnt_new_r   <= gnt_new_n;
    end
  end

  assign gnt       = gnt_r;
  assign gnt_idx   = gnt_idx_r;
  assign gnt_valid = gnt_valid_r;
  assign gnt_new   = gnt_new_r;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Bench for rr_arbiter8: three instances (MAX_HOLD 4, 2, 0) share clock, reset
// and requests; directed steps plus random traffic are checked against a model.
module tb_rr_arbiter8;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic [7:0] g   [3];
  logic [2:0] gi  [3];
  logic       gv  [3];
  logic       gn  [3];

  int checks = 0;
  int errors = 0;

  // Reference model: current holder (-1 when idle), cycles held, scan start.
  int mh      [3] = '{4, 2, 0};
  int m_h     [3];
  int m_held  [3];
  int m_start [3];
  bit m_new   [3];

  rr_arbiter8 #(.MAX_HOLD(4)) dut4 (.clk(clk), .rst(rst), .req(req),
    .gnt(g[0]), .gnt_idx(gi[0]), .gnt_valid(gv[0]), .gnt_new(gn[0]));
  rr_arbiter8 #(.MAX_HOLD(2)) dut2 (.clk(clk), .rst(rst), .req(req),
    .gnt(g[1]), .gnt_idx(gi[1]), .gnt_valid(gv[1]), .gnt_new(gn[1]));
  rr_arbiter8 #(.MAX_HOLD(0)) dut0 (.clk(clk), .rst(rst), .req(req),
    .gnt(g[2]), .gnt_idx(gi[2]), .gnt_valid(gv[2]), .gnt_new(gn[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [7:0] r, input int start);
    for (int k = 0; k < 8; k++)
      if (r[(start + k) % 8]) return (start + k) % 8;
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_h[i] = -1; m_held[i] = 0; m_start[i] = 0; m_new[i] = 1'b0;
    end
  endtask

  task automatic model_grant(input int i, input logic [7:0] r);
    int w;
    w = pick(r, m_start[i]);
    m_h[i] = w; m_held[i] = 1; m_new[i] = 1'b1; m_start[i] = (w + 1) % 8;
  endtask

  task automatic model_edge(input logic [7:0] r);
    logic [7:0] others;
    for (int i = 0; i < 3; i++) begin
      m_new[i] = 1'b0;
      if (m_h[i] < 0) begin
        if (r != 8'h00) model_grant(i, r);
      end else if (!r[m_h[i]]) begin
        if (r != 8'h00) model_grant(i, r);
        else m_h[i] = -1;
      end else if (mh[i] == 0 || m_held[i] < mh[i]) begin
        if (m_held[i] < 255) m_held[i]++;
      end else begin
        others = r;
        others[m_h[i]] = 1'b0;
        if (others != 8'h00) model_grant(i, r);
      end
    end
  endtask

  task automatic check_all();
    logic [7:0] eg;
    for (int i = 0; i < 3; i++) begin
      eg = 8'h00;
      if (m_h[i] >= 0) eg[m_h[i]] = 1'b1;
      chk($sformatf("gnt[%0d]", i), g[i], eg);
      chk($sformatf("gnt_idx[%0d]", i), {5'd0, gi[i]}, (m_h[i] < 0) ? 8'h00 : 8'(m_h[i]));
      chk($sformatf("gnt_valid[%0d]", i), {7'd0, gv[i]}, {7'd0, (m_h[i] >= 0)});
      chk($sformatf("gnt_new[%0d]", i), {7'd0, gn[i]}, {7'd0, m_new[i]});
    end
  endtask

  task automatic step(input logic [7:0] r);
    req = r;
    @(posedge clk);
    model_edge(r);
    #1;
    check_all();
  endtask

  // Asynchronous reset pulse between clock edges; outputs must clear at once.
  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_gnt[%0d]", i), g[i], 8'h00);
      chk($sformatf("rst_idx[%0d]", i), {5'd0, gi[i]}, 8'h00);
      chk($sformatf("rst_valid[%0d]", i), {7'd0, gv[i]}, 8'h00);
      chk($sformatf("rst_new[%0d]", i), {7'd0, gn[i]}, 8'h00);
    end
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] r;
    rst = 1'b1;
    req = 8'h00;
    model_reset();
    #12;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("init_gnt[%0d]", i), g[i], 8'h00);
      chk($sformatf("init_valid[%0d]", i), {7'd0, gv[i]}, 8'h00);
    end
    rst = 1'b0;

    // Reset mid-grant, then first grant after release.
    step(8'h04);
    chk("grant_04", g[0], 8'h04);
    async_reset();
    step(8'h01);
    chk("post_rst_grant", g[0], 8'h01);
    chk("post_rst_new", {7'd0, gn[0]}, 8'h01);

    // Single requesters in turn, one idle cycle between grants.
    step(8'h00);
    for (int i = 0; i < 8; i++) begin
      for (int c = 0; c < 3; c++) begin
        step(8'(1 << i));
        chk($sformatf("single_gnt_%0d", i), g[0], 8'(1 << i));
        chk($sformatf("single_idx_%0d", i), {5'd0, gi[0]}, 8'(i));
        chk($sformatf("single_new_%0d_%0d", i, c), {7'd0, gn[0]}, (c == 0) ? 8'h01 : 8'h00);
      end
      step(8'h00);
      chk($sformatf("single_idle_%0d", i), {7'd0, gv[0]}, 8'h00);
    end

    // Round-robin fairness with all requesters active.
    for (int c = 0; c < 33; c++) begin
      step(8'hFF);
      chk($sformatf("rr_idx_%0d", c), {5'd0, gi[0]}, 8'((c / 4) % 8));
      chk($sformatf("rr_new_%0d", c), {7'd0, gn[0]}, (c % 4 == 0) ? 8'h01 : 8'h00);
    end

    // Wrap-around: requester 6 wins, then 0 beats 6 from ptr=7.
    step(8'h00);
    step(8'h40);
    chk("wrap_first6", g[0], 8'h40);
    step(8'h00);
    step(8'h41);
    chk("wrap_to0", {5'd0, gi[0]}, 8'h00);
    chk("wrap_valid", {7'd0, gv[0]}, 8'h01);
    step(8'h40);
    chk("wrap_then6", g[0], 8'h40);
    chk("wrap_then6_new", {7'd0, gn[0]}, 8'h01);

    // Back-to-back release from holder 2 to waiting requester 5.
    step(8'h00);
    step(8'h04);
    step(8'h24);
    chk("b2b_hold2", g[0], 8'h04);
    step(8'h20);
    chk("b2b_gnt", g[0], 8'h20);
    chk("b2b_new", {7'd0, gn[0]}, 8'h01);

    // Saturated hold, late preemption, and unlimited mode.
    step(8'h00);
    for (int c = 0; c < 10; c++) begin
      step(8'h08);
      chk($sformatf("sat_hold_%0d", c), g[1], 8'h08);
    end
    step(8'h0A);
    chk("sat_preempt_idx", {5'd0, gi[1]}, 8'h01);
    chk("sat_preempt_new", {7'd0, gn[1]}, 8'h01);
    for (int c = 0; c < 20; c++) begin
      step(8'h0A);
      chk($sformatf("unlim_idx_%0d", c), {5'd0, gi[2]}, 8'h03);
    end

    // Random traffic against the model, with occasional async resets.
    r = 8'h00;
    for (int n = 0; n < 600; n++) begin
      case ($urandom_range(0, 4))
        0: r = 8'h00;
        1: r = 8'(1 << $urandom_range(0, 7));
        2: r = r;
        3: r = r | 8'(1 << $urandom_range(0, 7));
        default: r = 8'($urandom);
      endcase
      step(r);
      if ($urandom_range(0, 99) == 0) async_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
